pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the MIPS core. It succeeds the fixed D->E register and can be instantiated at any stage boundary.
- Carries a PC, delay-slot flag, exception code and an opaque payload bundle.
- Uses a valid/ready handshake backed by a one-entry skid buffer.
- Supports hazard-bubble insertion, which preserves PC and BD for EPC.
- Supports interrupt/exception flush, which redirects to the handler PC.

---
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register (valid/ready).
// Main entry M drives out_*; optional skid entry S decouples in_ready from
// out_ready. Optional feature macro: PIPE_STAGE_SKID_EN (defined = M+S skid
// buffer with registered in_ready; undefined = single entry, skid_full=0).
// Supports hazard bubbles (NOP keeping PC/BD for EPC) and flush to HANDLER_PC.
module pipe_stage_reg #(
  parameter int              DATA_W     = 160,
  parameter int              PC_W       = 32,
  parameter int              EXC_W      = 5,
  parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [DATA_W-1:0] in_payload,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_nop,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  output logic [DATA_W-1:0] out_payload,
  output logic              skid_full
);

  typedef struct packed {
    logic              valid;
    logic              nop;
    logic [PC_W-1:0]   pc;
    logic              bd;
    logic [EXC_W-1:0]  exc;
    logic [DATA_W-1:0] payload;
  } entry_t;

  entry_t m_q, m_d;
  entry_t e, flush_e;
  logic   acc, ins, e_vld, drain;

`ifdef PIPE_STAGE_SKID_EN
  entry_t s_q, s_d;
  // Ready only from registered skid state, so no out_ready->in_ready path.
  assign in_ready  = reset & ~s_q.valid & ~flush;
  assign skid_full = s_q.valid;
`else
  // Single entry: can take a beat when empty or when M leaves this edge.
  assign in_ready  = reset & ~flush & (~m_q.valid | out_ready);
  assign skid_full = 1'b0;
`endif

  assign acc   = in_valid & in_ready & ~bubble;
  assign ins   = in_valid & in_ready & bubble;
  assign e_vld = acc | ins;
  assign drain = m_q.valid & out_ready;

  // Build the incoming entry: a bubble keeps PC/BD (for EPC) but drops exc/payload.
  always_comb begin
    e         = '0;
    e.valid   = 1'b1;
    e.pc      = in_pc;
    e.bd      = in_bd;
    if (bubble) begin
      e.nop     = 1'b1;
    end else begin
      e.exc     = in_exc;
      e.payload = in_payload;
    end
    flush_e       = '0;
    flush_e.valid = 1'b1;
    flush_e.nop   = 1'b1;
    flush_e.pc    = HANDLER_PC;
  end

  // Next-state: flush wins, then FIFO refill of M (from S first, else E).
  always_comb begin
    m_d = m_q;
`ifdef PIPE_STAGE_SKID_EN
    s_d = s_q;
    if (flush) begin
      m_d = flush_e;
      s_d = '0;
    end else if (!m_q.valid || drain) begin
      if (s_q.valid) begin
        m_d = s_q;
        s_d = e_vld ? e : '0;
      end else if (e_vld) begin
        m_d = e;
      end else begin
        m_d.valid = 1'b0;
      end
    end else if (e_vld) begin
      s_d = e;
    end
`else
    if (flush) begin
      m_d = flush_e;
    end else if (!m_q.valid || drain) begin
      if (e_vld) m_d = e;
      else       m_d.valid = 1'b0;
    end
`endif
  end

  // Entry storage with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      s_q <= '0;
`endif
    end else begin
      m_q <= m_d;
`ifdef PIPE_STAGE_SKID_EN
      s_q <= s_d;
`endif
    end
  end

  assign out_valid   = m_q.valid;
  assign out_nop     = m_q.nop;
  assign out_pc      = m_q.pc;
  assign out_bd      = m_q.bd;
  assign out_exc     = m_q.exc;
  assign out_payload = m_q.payload;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg (either skid build).
module tb_pipe_stage_reg;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_bd, bubble, flush;
  logic [31:0]  in_pc;
  logic [4:0]   in_exc;
  logic [159:0] in_payload;
  logic         out_valid, out_ready, out_nop, out_bd, skid_full;
  logic [31:0]  out_pc;
  logic [4:0]   out_exc;
  logic [159:0] out_payload;

  pipe_stage_reg #(.DATA_W(160), .PC_W(32), .EXC_W(5), .HANDLER_PC(32'h0000_4180)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc(in_exc), .in_payload(in_payload), .bubble(bubble), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_nop(out_nop), .out_pc(out_pc),
    .out_bd(out_bd), .out_exc(out_exc), .out_payload(out_payload), .skid_full(skid_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         nop;
    logic [31:0]  pc;
    logic         bd;
    logic [4:0]   exc;
    logic [159:0] pl;
  } ex_t;

  ex_t q[$];
  int  n_chk = 0;
  int  n_err = 0;
  bit  last_acc;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] mkpl(input logic [31:0] p);
    return {p, ~p, p ^ 32'h5a5a5a5a, p + 32'd1, p[15:0], p[31:16]};
  endfunction

  function automatic bit exp_rdy();
    if (!reset || flush) return 1'b0;
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  // One clock: check outputs against the model at negedge, then advance it.
  task automatic cyc();
    bit rdy, acc, ins, drn, fl, rs;
    ex_t e;
    @(negedge clk);
    rdy = exp_rdy();
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, q.size() > 0);
    chk("skid_full", skid_full, SKID && q.size() == 2);
    if (q.size() > 0) begin
      chk("out_nop", out_nop, q[0].nop);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_bd", out_bd, q[0].bd);
      chk("out_exc", out_exc, q[0].exc);
      chk("out_payload", out_payload, q[0].pl);
    end
    acc = in_valid && rdy && !bubble;
    ins = in_valid && rdy && bubble;
    drn = (q.size() > 0) && out_ready;
    fl  = flush;
    rs  = reset;
    e   = '{nop: ins, pc: in_pc, bd: in_bd, exc: ins ? 5'd0 : in_exc,
            pl: ins ? 160'd0 : in_payload};
    @(posedge clk);
    if (rs) begin
      if (drn) void'(q.pop_front());
      if (fl) begin
        q.delete();
        q.push_back('{nop: 1'b1, pc: 32'h0000_4180, bd: 1'b0, exc: 5'd0, pl: 160'd0});
      end else if (acc || ins) begin
        q.push_back(e);
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic bd, input logic [4:0] exc);
    in_valid = 1'b1; in_pc = pc; in_bd = bd; in_exc = exc; in_payload = mkpl(pc);
  endtask

  // Present a beat and hold it until the model says it was consumed.
  task automatic send(input logic [31:0] pc);
    drive(pc, 1'b0, 5'd0);
    last_acc = 1'b0;
    for (int i = 0; i < 20 && !last_acc; i++) cyc();
    if (!last_acc) chk("send_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b0; bubble = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(32'h3000, 1'b0, 5'd0);
    #2;
    // reset held with upstream valid
    cyc(); cyc();
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_nop", out_nop, 1'b0);
    chk("rst_payload", out_payload, 160'd0);
    reset = 1'b1;
    // stream, full throughput
    send(32'h3000); send(32'h3004); send(32'h3008);
    in_valid = 1'b0; cyc(); cyc();

    // backpressure: second beat lands in skid (skid build) or waits
    out_ready = 1'b0;
    send(32'h3000);
    drive(32'h3004, 1'b0, 5'd0);
    cyc(); cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !last_acc; i++) cyc();
    in_valid = 1'b0;
    repeat (3) cyc();

    // bubble keeps PC/BD, then the held beat is delivered
    drive(32'h3010, 1'b1, 5'd4); bubble = 1'b1;
    cyc();
    bubble = 1'b0;
    cyc();
    chk("bubble_then_acc", last_acc, 1'b1);
    in_valid = 1'b0;
    repeat (3) cyc();

    // flush with stage full, twice (idempotent), then drain the flush NOP
    out_ready = 1'b0;
    send(32'h3020);
    drive(32'h3024, 1'b0, 5'd2);
    cyc();
    drive(32'h3028, 1'b0, 5'd0); flush = 1'b1;
    cyc(); cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    // async reset mid-cycle with an entry held
    out_ready = 1'b0;
    send(32'h3040);
    #3 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_pc", out_pc, 32'd0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_skid_full", skid_full, 1'b0);
    q.delete();
    in_valid = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();

    // in_ready vs out_ready while M is full
    send(32'h3050);
    in_valid = 1'b0;
    out_ready = 1'b1; #1 chk("rdy_follow_hi", in_ready, exp_rdy());
    out_ready = 1'b0; #1 chk("rdy_follow_lo", in_ready, exp_rdy());
    out_ready = 1'b1;
    repeat (2) cyc();

    // random traffic
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || last_acc) begin
        if ($urandom_range(0, 9) < 7) drive($urandom, 1'($urandom), 5'($urandom));
        else in_valid = 1'b0;
      end
      bubble    = ($urandom_range(0, 9) < 2);
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    flush = 1'b0; bubble = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("final_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
